// File: rtl/beep_scheduler.sv
// Piezo beep sequencer: four prioritised request classes, preemptive, slot-timed bursts.
// Optional BEEP_MUTE_EN adds a `mute` input that gates beep on the output path only.
module beep_scheduler #(
  parameter int SLOT_CYCLES = 50_000_000,
  parameter int HP0 = 95548,
  parameter int HP1 = 85136,
  parameter int HP2 = 75838,
  parameter int HP3 = 47778,
  parameter int N0 = 4,
  parameter int N1 = 4,
  parameter int N2 = 1,
  parameter int N3 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       cancel,
`ifdef BEEP_MUTE_EN
  input  logic       mute,
`endif
  output logic       beep,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done,
  output logic [1:0] done_id
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, TONE = 2'd1, GAP = 2'd2} state_t;

  state_t          state_r, state_n;
  logic [3:0]      pending_r, pending_n, req_eff_s;
  logic [1:0]      active_id_r, active_id_n;
  logic [3:0]      burst_r, burst_n;
  logic [SW-1:0]   slot_r, slot_n;
  logic [16:0]     hp_r, hp_n;
  logic            beep_r, beep_n;
  logic            busy_r;
  logic            done_r, done_n;
  logic [1:0]      done_id_r, done_id_n;
  logic            gnt_valid_s, preempt_s, do_grant_s;
  logic [1:0]      gnt_idx_s;

  function automatic logic [16:0] hp_of(input logic [1:0] k);
    case (k)
      2'd0:    hp_of = 17'(HP0);
      2'd1:    hp_of = 17'(HP1);
      2'd2:    hp_of = 17'(HP2);
      2'd3:    hp_of = 17'(HP3);
      default: hp_of = 17'(HP3);
    endcase
  endfunction

  function automatic logic [3:0] n_of(input logic [1:0] k);
    case (k)
      2'd0:    n_of = 4'(N0);
      2'd1:    n_of = 4'(N1);
      2'd2:    n_of = 4'(N2);
      2'd3:    n_of = 4'(N3);
      default: n_of = 4'(N3);
    endcase
  endfunction

  // Lowest pending index wins; preemption only by a strictly higher-priority class
  always_comb begin
    gnt_valid_s = 1'b1;
    gnt_idx_s   = 2'd0;
    if (pending_r[0])      gnt_idx_s = 2'd0;
    else if (pending_r[1]) gnt_idx_s = 2'd1;
    else if (pending_r[2]) gnt_idx_s = 2'd2;
    else if (pending_r[3]) gnt_idx_s = 2'd3;
    else                   gnt_valid_s = 1'b0;
    preempt_s = gnt_valid_s && (gnt_idx_s < active_id_r);
  end

  // Next-state, counters, request capture and done pulse
  always_comb begin
    req_eff_s   = req & ~((state_r != IDLE) ? (4'b0001 << active_id_r) : 4'b0000);
    state_n     = state_r;
    pending_n   = pending_r | req_eff_s;
    active_id_n = active_id_r;
    burst_n     = burst_r;
    slot_n      = slot_r;
    hp_n        = hp_r;
    beep_n      = beep_r;
    done_n      = 1'b0;
    done_id_n   = done_id_r;
    do_grant_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (gnt_valid_s) do_grant_s = 1'b1;
        else             state_n = IDLE;
      end
      TONE: begin
        if (preempt_s) begin
          do_grant_s = 1'b1;
        end else if (slot_r == SLOT_LAST) begin
          slot_n  = '0;
          hp_n    = 17'd0;
          beep_n  = 1'b0;
          burst_n = burst_r - 4'd1;
          if (burst_r != 4'd1) begin
            state_n = GAP;
          end else begin
            done_n    = 1'b1;
            done_id_n = active_id_r;
            if (gnt_valid_s) do_grant_s = 1'b1;
            else             state_n = IDLE;
          end
        end else begin
          slot_n = slot_r + SW'(1);
          if (hp_r == hp_of(active_id_r) - 17'd1) begin
            hp_n   = 17'd0;
            beep_n = ~beep_r;
          end else begin
            hp_n = hp_r + 17'd1;
          end
        end
      end
      GAP: begin
        if (preempt_s) begin
          do_grant_s = 1'b1;
        end else if (slot_r == SLOT_LAST) begin
          state_n = TONE;
          slot_n  = '0;
          hp_n    = 17'd0;
          beep_n  = 1'b0;
        end else begin
          slot_n = slot_r + SW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // cancel beats any grant or request on the same edge
    if (cancel) begin
      state_n     = IDLE;
      pending_n   = 4'b0000;
      active_id_n = active_id_r;
      burst_n     = 4'd0;
      slot_n      = '0;
      hp_n        = 17'd0;
      beep_n      = 1'b0;
      done_n      = 1'b0;
      done_id_n   = done_id_r;
    end else if (do_grant_s) begin
      state_n              = TONE;
      active_id_n          = gnt_idx_s;
      burst_n              = n_of(gnt_idx_s);
      slot_n               = '0;
      hp_n                 = 17'd0;
      beep_n               = 1'b0;
      pending_n[gnt_idx_s] = 1'b0;
    end else begin
      pending_n = pending_r | req_eff_s;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pending_r   <= 4'b0000;
      active_id_r <= 2'd0;
      burst_r     <= 4'd0;
      slot_r      <= '0;
      hp_r        <= 17'd0;
      beep_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      done_id_r   <= 2'd0;
    end else begin
      state_r     <= state_n;
      pending_r   <= pending_n;
      active_id_r <= active_id_n;
      burst_r     <= burst_n;
      slot_r      <= slot_n;
      hp_r        <= hp_n;
      beep_r      <= beep_n;
      busy_r      <= (state_n != IDLE);
      done_r      <= done_n;
      done_id_r   <= done_id_n;
    end
  end

`ifdef BEEP_MUTE_EN
  assign beep = beep_r & ~mute;
`else
  assign beep = beep_r;
`endif
  assign busy      = busy_r;
  assign active_id = active_id_r;
  assign done      = done_r;
  assign done_id   = done_id_r;

endmodule

// File: tb/tb_beep_scheduler.sv
// Scoreboard bench for beep_scheduler: expected done events are queued by the stimulus
// thread and checked by a negedge monitor; beep/busy/active_id checked against a small model.
module tb_beep_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       cancel;
`ifdef BEEP_MUTE_EN
  logic       mute;
`endif
  logic       beep, busy, done;
  logic [1:0] active_id, done_id;

  beep_scheduler #(
    .SLOT_CYCLES(20), .HP0(2), .HP1(3), .HP2(4), .HP3(5),
    .N0(3), .N1(2), .N2(1), .N3(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .cancel(cancel),
`ifdef BEEP_MUTE_EN
    .mute(mute),
`endif
    .beep(beep), .busy(busy), .active_id(active_id),
    .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] id;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  bit   mute_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_done(input logic [1:0] id, input int at);
    exp_t e;
    e.id = id;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(input int t);
    if (cyc > t) check("sequencing", cyc, t);
    while (cyc < t) step(1);
  endtask

  task automatic tone_check(input int start, input int hp, input int id);
    for (int t = start; t < start + 20; t++) begin
      goto(t);
      check("tone_beep", int'(beep), mute_on ? 0 : ((t - start) / hp) % 2);
      check("tone_busy", int'(busy), 1);
      check("tone_id", int'(active_id), id);
    end
  endtask

  task automatic gap_check(input int start, input int len);
    for (int t = start; t < start + len; t++) begin
      goto(t);
      check("gap_beep", int'(beep), 0);
      check("gap_busy", int'(busy), 1);
    end
  endtask

  // Monitor: every done pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done_id=%0d at cycle %0d, none expected", done_id, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_id", int'(done_id), int'(mon_e.id));
        check("done_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    int c0;
    int c1;
    req = 4'b0000;
    cancel = 1'b0;
    rst = 1'b1;
`ifdef BEEP_MUTE_EN
    mute = 1'b0;
`endif
    step(3);
    check("rst_beep", int'(beep), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_active_id", int'(active_id), 0);
    check("rst_done", int'(done), 0);
    check("rst_done_id", int'(done_id), 0);
    rst = 1'b0;
    step(2);

    // 1: single success burst
    c0 = cyc;
    req = 4'b1000;
    expect_done(2'd3, c0 + 62);
    step(1);
    req = 4'b0000;
    check("t1_busy_latency", int'(busy), 0);
    tone_check(c0 + 2, 5, 3);
    gap_check(c0 + 22, 20);
    tone_check(c0 + 42, 5, 3);
    goto(c0 + 63);
    check("t1_busy_after", int'(busy), 0);
    check("t1_queue", exp_q.size(), 0);
    goto(c0 + 70);

    // 2: simultaneous class 1 and class 2, back to back
    c0 = cyc;
    req = 4'b0110;
    expect_done(2'd1, c0 + 62);
    expect_done(2'd2, c0 + 82);
    step(1);
    req = 4'b0000;
    tone_check(c0 + 2, 3, 1);
    gap_check(c0 + 22, 20);
    tone_check(c0 + 42, 3, 1);
    tone_check(c0 + 62, 4, 2);
    goto(c0 + 85);
    check("t2_busy_after", int'(busy), 0);
    check("t2_queue", exp_q.size(), 0);

    // 3: class 0 preempts class 3 in its gap
    c0 = cyc;
    req = 4'b1000;
    expect_done(2'd0, c0 + 127);
    step(1);
    req = 4'b0000;
    tone_check(c0 + 2, 5, 3);
    gap_check(c0 + 22, 3);
    goto(c0 + 25);
    req = 4'b0001;
    step(1);
    req = 4'b0000;
    check("t3_still_3", int'(active_id), 3);
    tone_check(c0 + 27, 2, 0);
    gap_check(c0 + 47, 20);
    goto(c0 + 140);
    check("t3_busy_after", int'(busy), 0);
    check("t3_active_hold", int'(active_id), 0);
    check("t3_queue", exp_q.size(), 0);

    // 4: lower priority request never preempts
    c0 = cyc;
    req = 4'b0010;
    expect_done(2'd1, c0 + 62);
    expect_done(2'd2, c0 + 82);
    step(1);
    req = 4'b0000;
    goto(c0 + 10);
    req = 4'b0100;
    step(1);
    req = 4'b0000;
    goto(c0 + 30);
    check("t4_no_preempt", int'(active_id), 1);
    tone_check(c0 + 42, 3, 1);
    tone_check(c0 + 62, 4, 2);
    goto(c0 + 85);
    check("t4_busy_after", int'(busy), 0);
    check("t4_queue", exp_q.size(), 0);

    // 5: cancel overrides a simultaneous request
    c0 = cyc;
    req = 4'b1000;
    step(1);
    req = 4'b0000;
    goto(c0 + 10);
    check("t5_beep_before", int'(beep), 1);
    cancel = 1'b1;
    req = 4'b1001;
    step(1);
    cancel = 1'b0;
    req = 4'b0000;
    check("t5_beep", int'(beep), 0);
    check("t5_busy", int'(busy), 0);
    for (int i = 0; i < 40; i++) begin
      step(1);
      check("t5_idle", int'(busy), 0);
    end

    // 6: reset mid-gap, then a clean class 2 tone
    c0 = cyc;
    req = 4'b0001;
    step(1);
    req = 4'b0000;
    goto(c0 + 30);
    check("t6_in_gap", int'(busy), 1);
    rst = 1'b1;
    step(1);
    check("t6_rst_beep", int'(beep), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_active_id", int'(active_id), 0);
    check("t6_rst_done", int'(done), 0);
    check("t6_rst_done_id", int'(done_id), 0);
    rst = 1'b0;
    step(1);
`ifdef BEEP_MUTE_EN
    mute = 1'b1;
    mute_on = 1'b1;
`endif
    c1 = cyc;
    req = 4'b0100;
    expect_done(2'd2, c1 + 22);
    step(1);
    req = 4'b0000;
    tone_check(c1 + 2, 4, 2);
    goto(c1 + 25);
    check("t6_busy_after", int'(busy), 0);
    check("t6_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
